uart_tx: RTL and testbench

//  Buffered 8N1 UART transmitter: the transmit half of the serial link paired with the UART receiver.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_if.sv | 13 +
 rtl/uart_tx_fifo.sv | 63 ++++++
 rtl/uart_tx.sv | 167 ++++++++++++++++
 tb/tb_uart_tx.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
//   - 3-bit FSM state encodings and the enum built from them
//   - DEFAULT_CYCLES_PER_BIT: clk cycles per bit period for the default build
//   - frame_cycles(): total clk cycles taken by one frame for a given setup
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } tx_state_e;

  localparam int DEFAULT_CYCLES_PER_BIT = 86;

  // Start + 8 data + optional parity + stop bit(s), each one bit period long.
  function automatic int frame_cycles(input int cpb, input int parity_en, input int stop_bits);
    return (10 + parity_en + stop_bits - 1) * cpb;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a data source and the UART transmitter.
//   tx_data  : byte to send            (source -> transmitter)
//   tx_valid : tx_data is valid        (source -> transmitter)
//   tx_ready : transmitter can accept  (transmitter -> source)
// A byte transfers on a rising clk edge where tx_valid && tx_ready.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with show-ahead read data.
//   clk, rst : clock, asynchronous active-low reset (empties the FIFO)
//   wr_en    : write wr_data this edge (ignored when full)
//   rd_en    : pop the head this edge (ignored when empty)
//   rd_data  : current head of the FIFO, valid whenever !empty
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : number of stored bytes
// DEPTH must be a power of 2 so the pointers wrap by natural overflow.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_wr, do_rd;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    // Simultaneous write and read leaves the count unchanged.
    count_d  = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage holds data only; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter: bytes arrive over a valid/ready handshake into a
// small FIFO and are sent LSB-first as start, 8 data, optional parity and
// 1 or 2 stop bits. Queued frames go out back-to-back.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset; abandons any frame in flight
//   s_if       : byte handshake (tx_data, tx_valid in; tx_ready out = !full)
//   tx_bit     : registered serial line, idles high
//   tx_busy    : high from the first start-bit cycle to the last stop-bit cycle
//   tx_done    : one-cycle pulse on the clk after each frame's last stop-bit cycle
//   fifo_count : bytes waiting in the FIFO, excluding the frame in flight
module uart_tx
  import uart_pkg::*;
#(
  parameter int CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT,
  parameter int FIFO_DEPTH     = 4,
  parameter int PARITY_EN      = 0,
  parameter int PARITY_ODD     = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_if.slave                      s_if,
  output logic                          tx_bit,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int              CW        = $clog2(CYCLES_PER_BIT);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(CYCLES_PER_BIT - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_bit_q, tx_bit_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          load;
  logic          bit_end;

  logic [7:0]    fifo_rd_data;
  logic          fifo_full, fifo_empty;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s_if.tx_valid),
    .wr_data (s_if.tx_data),
    .rd_en   (load),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign s_if.tx_ready = !fifo_full;
  assign tx_bit        = tx_bit_q;
  assign tx_busy       = busy_q;
  assign tx_done       = done_q;
  assign bit_end       = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        // idx counts stop bits so each stays exactly one bit period long.
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == STOP_LAST) begin
            done_d  = 1'b1;
            idx_d   = '0;
            load    = !fifo_empty;
            state_d = fifo_empty ? IDLE : START;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d = fifo_rd_data;
      par_d   = (^fifo_rd_data) ^ (PARITY_ODD != 0);
      cnt_d   = '0;
      idx_d   = '0;
    end

    // The line value is registered from the next state so it changes
    // exactly on the bit boundary, without combinational glitches.
    unique case (state_d)
      START:   tx_bit_d = 1'b0;
      DATA:    tx_bit_d = shift_d[0];
      PARITY:  tx_bit_d = par_d;
      default: tx_bit_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      tx_bit_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      tx_bit_q <= tx_bit_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Byte being shifted out and its parity; only meaningful while a frame runs.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four transmitters (8N1, even parity, odd parity, two stop
// bits) share one stimulus stream; a frame-level model predicts every output
// each cycle, a serial receiver decodes the 8N1 line, and directed checks pin
// hand-computed timing and bit values.
module tb_uart_tx;
  localparam int CPB   = 86;
  localparam int DEPTH = 4;
  localparam int ND    = 4;
  localparam int PE [ND] = '{0, 1, 1, 0};
  localparam int PO [ND] = '{0, 0, 1, 0};
  localparam int SB [ND] = '{1, 1, 1, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]    din = 8'h00;
  logic [ND-1:0] v   = '0;
  wire  [ND-1:0] rdy, bitv, busyv, donev;
  wire  [2:0]    fc [ND];

  uart_tx_if if0 ();
  uart_tx_if if1 ();
  uart_tx_if if2 ();
  uart_tx_if if3 ();
  assign if0.tx_data = din; assign if0.tx_valid = v[0]; assign rdy[0] = if0.tx_ready;
  assign if1.tx_data = din; assign if1.tx_valid = v[1]; assign rdy[1] = if1.tx_ready;
  assign if2.tx_data = din; assign if2.tx_valid = v[2]; assign rdy[2] = if2.tx_ready;
  assign if3.tx_data = din; assign if3.tx_valid = v[3]; assign rdy[3] = if3.tx_ready;

  uart_tx #(.CYCLES_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .s_if(if0), .tx_bit(bitv[0]), .tx_busy(busyv[0]), .tx_done(donev[0]), .fifo_count(fc[0]));
  uart_tx #(.CYCLES_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .s_if(if1), .tx_bit(bitv[1]), .tx_busy(busyv[1]), .tx_done(donev[1]), .fifo_count(fc[1]));
  uart_tx #(.CYCLES_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .s_if(if2), .tx_bit(bitv[2]), .tx_busy(busyv[2]), .tx_done(donev[2]), .fifo_count(fc[2]));
  uart_tx #(.CYCLES_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .s_if(if3), .tx_bit(bitv[3]), .tx_busy(busyv[3]), .tx_done(donev[3]), .fifo_count(fc[3]));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [7:0]  mq   [ND][DEPTH];
  int          mcnt [ND];
  logic [11:0] mfr  [ND];
  int          mlen [ND];
  int          mpos [ND];
  bit          minf [ND];
  bit          mdone[ND];

  function automatic logic [11:0] frame_of(input logic [7:0] b, input int i);
    logic [11:0] f;
    logic p;
    f      = '1;          // stop bits and idle are ones
    f[0]   = 1'b0;        // start bit
    f[8:1] = b;           // data, LSB first
    p = ^b;
    if (PO[i] != 0) p = ~p;
    if (PE[i] != 0) f[9] = p;
    return f;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ND; i++) begin
      mcnt[i] = 0; minf[i] = 1'b0; mdone[i] = 1'b0; mpos[i] = 0;
    end
  endfunction

  function automatic logic exp_bit(input int i);
    if (!minf[i]) return 1'b1;
    return mfr[i][mpos[i] / CPB];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else begin
      for (int i = 0; i < ND; i++) begin
        bit acc, ending, pop;
        int c0;
        c0     = mcnt[i];
        acc    = v[i] && (c0 < DEPTH);
        ending = minf[i] && (mpos[i] == mlen[i] - 1);
        pop    = (c0 > 0) && (!minf[i] || ending);
        mdone[i] = ending;
        if (ending) minf[i] = 1'b0;
        if (minf[i]) mpos[i]++;
        if (pop) begin
          mfr[i]  = frame_of(mq[i][0], i);
          mlen[i] = (10 + PE[i] + SB[i] - 1) * CPB;
          mpos[i] = 0;
          minf[i] = 1'b1;
          for (int j = 0; j < DEPTH - 1; j++) mq[i][j] = mq[i][j+1];
          mcnt[i]--;
        end
        if (acc) begin
          mq[i][mcnt[i]] = din;
          mcnt[i]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < ND; i++) begin
        chk($sformatf("tx_bit[%0d]", i),     32'(bitv[i]),  32'(exp_bit(i)));
        chk($sformatf("tx_busy[%0d]", i),    32'(busyv[i]), 32'(minf[i]));
        chk($sformatf("tx_done[%0d]", i),    32'(donev[i]), 32'(mdone[i]));
        chk($sformatf("fifo_count[%0d]", i), 32'(fc[i]),    32'(mcnt[i]));
        chk($sformatf("tx_ready[%0d]", i),   32'(rdy[i]),   32'(mcnt[i] < DEPTH));
      end
    end
  end

  // ---------------- 8N1 receiver on DUT 0 ----------------
  logic [7:0] rxq[$];
  int rgen = 0;
  always @(negedge rst) rgen++;

  initial begin : rx
    forever begin
      int g;
      logic [7:0] b;
      bit ok;
      @(negedge clk);
      if (rst && bitv[0] == 1'b0) begin
        g  = rgen;
        ok = 1'b1;
        b  = 8'h00;
        repeat (CPB / 2) @(negedge clk);
        if (bitv[0] != 1'b0) ok = 1'b0;
        for (int j = 0; j < 8; j++) begin
          repeat (CPB) @(negedge clk);
          b[j] = bitv[0];
        end
        repeat (CPB) @(negedge clk);
        if (bitv[0] != 1'b1) ok = 1'b0;
        if (ok && g == rgen) rxq.push_back(b);
      end
    end
  end

  // busy/done monitor for DUT 0
  int cyc = 0, bfirst = -1, blast = -1, bcnt = 0, dcnt0 = 0;
  always @(negedge clk) begin
    cyc++;
    if (busyv[0]) begin
      if (bfirst < 0) bfirst = cyc;
      blast = cyc;
      bcnt++;
    end
    if (donev[0]) dcnt0++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(posedge clk); #2;
  endtask

  task automatic push_all(input logic [7:0] b, input logic [ND-1:0] mask);
    logic [ND-1:0] take;
    int n;
    n   = 0;
    din = b;
    v   = mask;
    while (v != '0 && n < 3000) begin
      @(negedge clk);
      take = v & rdy;
      @(posedge clk); #2;
      v = v & ~take;
      n++;
    end
    if (v != '0) begin
      total++; bad++;
      $display("FAIL push_timeout pending=%0h required=0", v);
      v = '0;
    end
  endtask

  task automatic wait_idle();
    int n, quiet;
    n = 0; quiet = 0;
    while (quiet < 2 && n < 20000) begin
      @(negedge clk);
      n++;
      if (busyv == '0 && (fc[0] | fc[1] | fc[2] | fc[3]) == 3'd0) quiet++;
      else quiet = 0;
    end
    if (quiet < 2) begin
      total++; bad++;
      $display("FAIL idle_timeout busy=%0h required=0", busyv);
    end
    sync();
  endtask

  task automatic rx_expect(input string nm, input logic [7:0] b);
    if (rxq.size() == 0) begin
      total++; bad++;
      $display("FAIL %s actual=none required=%0h", nm, b);
    end else begin
      chk(nm, 32'(rxq.pop_front()), 32'(b));
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    logic a5b [8];
    logic [7:0] six [6];
    int ndone, dk, lows;
    int dks [ND];
    a5b = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    six = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    model_reset();
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tx_bit",   32'(bitv),  32'hF);
    chk("rst_busy",     32'(busyv), 32'h0);
    chk("rst_done",     32'(donev), 32'h0);
    chk("rst_ready",    32'(rdy),   32'hF);
    chk("rst_count",    32'(fc[0]), 32'h0);
    chk_en = 1'b1;
    rst = 1'b1;
    sync();

    // single 0xA5
    push_all(8'hA5, 4'hF);
    ndone = 0; dk = -1;
    for (int k = 0; k <= 900; k++) begin
      @(negedge clk);
      if (k == 1 || k == 86) chk("a5_start", 32'(bitv[0]), 32'h0);
      if (k >= 129 && k <= 731 && (k - 129) % 86 == 0)
        chk("a5_data", 32'(bitv[0]), 32'(a5b[(k - 129) / 86]));
      if (k == 817) chk("a5_stop", 32'(bitv[0]), 32'h1);
      if (donev[0]) begin ndone++; dk = k; end
    end
    chk("a5_done_cnt", 32'(ndone), 32'd1);
    chk("a5_done_at",  32'(dk),    32'd861);
    wait_idle();
    rx_expect("rx_a5", 8'hA5);

    // parity on 0x07 (three ones)
    push_all(8'h07, 4'hF);
    for (int i = 0; i < ND; i++) dks[i] = -1;
    for (int k = 0; k <= 960; k++) begin
      @(negedge clk);
      if (k == 817) begin
        chk("par_even", 32'(bitv[1]), 32'h1);
        chk("par_odd",  32'(bitv[2]), 32'h0);
        chk("nopar_stop", 32'(bitv[0]), 32'h1);
      end
      for (int i = 0; i < ND; i++) if (donev[i] && dks[i] < 0) dks[i] = k;
    end
    chk("len_8n1",   32'(dks[0]), 32'd861);
    chk("len_par",   32'(dks[1]), 32'd947);
    chk("len_stop2", 32'(dks[3]), 32'd947);
    wait_idle();
    rx_expect("rx_07", 8'h07);

    // two stop bits, 0xFF twice back-to-back
    push_all(8'hFF, 4'hF);
    push_all(8'hFF, 4'hF);
    lows = 0;
    for (int k = 1; k <= 960; k++) begin
      @(negedge clk);
      if (k <= 946 && bitv[3] == 1'b0) lows++;
      if (k == 947) begin
        chk("stop2_next_start", 32'(bitv[3]),  32'h0);
        chk("stop2_done",       32'(donev[3]), 32'h1);
      end
    end
    chk("stop2_low_cycles", 32'(lows), 32'd86);
    wait_idle();
    rx_expect("rx_ff0", 8'hFF);
    rx_expect("rx_ff1", 8'hFF);

    // six frames through a full FIFO
    bfirst = -1; blast = -1; bcnt = 0; dcnt0 = 0;
    for (int i = 0; i < 5; i++) push_all(six[i], 4'hF);
    @(negedge clk);
    chk("full_ready", 32'(rdy[0]), 32'h0);
    chk("full_count", 32'(fc[0]),  32'd4);
    sync();
    push_all(six[5], 4'hF);
    wait_idle();
    chk("six_busy_cycles", 32'(bcnt),              32'd5160);
    chk("six_busy_span",   32'(blast - bfirst + 1), 32'd5160);
    chk("six_done_cnt",    32'(dcnt0),             32'd6);
    for (int i = 0; i < 6; i++) rx_expect($sformatf("rx_six%0d", i), six[i]);

    // push coinciding with the pop at fifo_count=2
    push_all(8'hC0, 4'hF);
    push_all(8'hC1, 4'hF);
    push_all(8'hC2, 4'hF);
    repeat (858) @(posedge clk);
    #2;
    chk("pp_pre_count", 32'(fc[0]), 32'd2);
    push_all(8'hC3, 4'h1);
    @(negedge clk);
    chk("pp_count", 32'(fc[0]),    32'd2);
    chk("pp_done",  32'(donev[0]), 32'h1);
    wait_idle();
    rx_expect("rx_pp0", 8'hC0);
    rx_expect("rx_pp1", 8'hC1);
    rx_expect("rx_pp2", 8'hC2);
    rx_expect("rx_pp3", 8'hC3);

    // reset during data bit 3 with two bytes queued
    push_all(8'hD0, 4'hF);
    push_all(8'hD1, 4'hF);
    push_all(8'hD2, 4'hF);
    repeat (379) @(posedge clk);
    #3;
    chk("mid_pre_bit3", 32'(fc[0]), 32'd2);
    rst = 1'b0;
    #1;
    chk("mid_rst_bit",   32'(bitv),     32'hF);
    chk("mid_rst_busy",  32'(busyv[0]), 32'h0);
    chk("mid_rst_count", 32'(fc[0]),    32'h0);
    chk("mid_rst_ready", 32'(rdy[0]),   32'h1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (1000) @(posedge clk);
    #2;
    push_all(8'h3C, 4'hF);
    wait_idle();
    rx_expect("rx_3c", 8'h3C);
    chk("rx_extra", 32'(rxq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
